// File: rtl/dma_pkg.sv
// Shared types and AXI constants for the DMA read master.
`timescale 1ns/1ps
package dma_pkg;

  // Read master sequencing states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         PAGE_BYTES = 4096;

  // ARSIZE encoding for a data bus of the given bit width (8..1024)
  function automatic logic [2:0] size_enc(input int width);
    logic [2:0] enc;
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == width) enc = i[2:0];
    end
    return enc;
  endfunction

endpackage

// File: rtl/axi_dma_rd_master.sv
// AXI4 read-channel master: one INCR burst per request, beats streamed
// straight through to the input buffer, one done pulse per burst.
`timescale 1ns/1ps
module axi_dma_rd_master
  import dma_pkg::*;
#(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_ID       = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_ctrl_read,
  input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
  input  logic [8:0]              i_num_trans,
  output logic                    o_read_done,
  output logic                    o_busy,
  output logic                    o_err,
  output logic [AXI_WIDTH_ID-1:0] M_ARID,
  output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
  output logic [7:0]              M_ARLEN,
  output logic [2:0]              M_ARSIZE,
  output logic [1:0]              M_ARBURST,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [AXI_WIDTH_ID-1:0] M_RID,
  input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RLAST,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  output logic [AXI_WIDTH_DA-1:0] o_data,
  output logic                    o_data_valid,
  input  logic                    i_data_ready
);

  localparam int                    BYTES_PER_BEAT = AXI_WIDTH_DA / 8;
  localparam logic [AXI_WIDTH_ID-1:0] ARID_C       = AXI_WIDTH_ID'(AXI_ID);

  state_e                  state_q;
  logic [AXI_WIDTH_AD-1:0] araddr_q;
  logic [7:0]              arlen_q;
  logic                    arvalid_q;
  logic [8:0]              beat_cnt_q;
  logic                    done_q;
  logic                    err_q;
  logic                    err_d;

  logic                    rd_active;
  logic                    beat_acc;
  logic                    last_beat;
  logic [31:0]             burst_end;
  logic                    page_cross;

  // Constant AR attributes
  assign M_ARID    = ARID_C;
  assign M_ARSIZE  = size_enc(AXI_WIDTH_DA);
  assign M_ARBURST = BURST_INCR;

  assign M_ARADDR    = araddr_q;
  assign M_ARLEN     = arlen_q;
  assign M_ARVALID   = arvalid_q;
  assign o_read_done = done_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != ST_IDLE);

  // R channel is a zero-latency pass-through while a burst is receiving
  assign rd_active    = (state_q == ST_DATA);
  assign M_RREADY     = rd_active & i_data_ready;
  assign o_data_valid = rd_active & M_RVALID;
  assign o_data       = M_RDATA;

  assign beat_acc  = M_RVALID & M_RREADY;
  assign last_beat = (beat_cnt_q == {1'b0, arlen_q});

  // End offset of the requested burst within its 4 KB page
  assign burst_end  = 32'(i_read_addr[11:0]) + 32'(i_num_trans) * 32'(BYTES_PER_BEAT);
  assign page_cross = (burst_end > 32'(PAGE_BYTES));

  // Sticky error: busy request, page crossing, bad response, RLAST misplacement or foreign RID
  always_comb begin
    err_d = err_q;
    if (i_ctrl_read && (state_q != ST_IDLE)) err_d = 1'b1;
    if (i_ctrl_read && (state_q == ST_IDLE) && page_cross) err_d = 1'b1;
    if (beat_acc && ((M_RRESP != RESP_OKAY) || (M_RLAST != last_beat) || (M_RID != ARID_C)))
      err_d = 1'b1;
  end

  // Burst sequencer with registered AR and done outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (i_ctrl_read) begin
            if (i_num_trans != 9'd0) begin
              araddr_q   <= i_read_addr;
              arlen_q    <= 8'(i_num_trans - 9'd1);
              beat_cnt_q <= '0;
              arvalid_q  <= 1'b1;
              state_q    <= ST_ADDR;
            end else begin
              // Empty transfer completes without touching the bus
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ADDR: begin
          if (M_ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            // Completion follows the beat count, not RLAST
            if (last_beat) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dma_rd_master.sv
// Directed bench for axi_dma_rd_master with a scripted AXI read slave.
`timescale 1ns/1ps
module tb_axi_dma_rd_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_ctrl_read = 1'b0;
  logic [31:0] i_read_addr = '0;
  logic [8:0]  i_num_trans = '0;
  logic        o_read_done, o_busy, o_err;
  logic [3:0]  M_ARID;
  logic [31:0] M_ARADDR;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE;
  logic [1:0]  M_ARBURST;
  logic        M_ARVALID;
  logic        M_ARREADY = 1'b0;
  logic [3:0]  M_RID = '0;
  logic [31:0] M_RDATA = '0;
  logic [1:0]  M_RRESP = '0;
  logic        M_RLAST = 1'b0;
  logic        M_RVALID = 1'b0;
  logic        M_RREADY;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_dma_rd_master dut (
    .clk(clk), .rstn(rstn),
    .i_ctrl_read(i_ctrl_read), .i_read_addr(i_read_addr), .i_num_trans(i_num_trans),
    .o_read_done(o_read_done), .o_busy(o_busy), .o_err(o_err),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Beat payload the slave returns: memory-like word address scrambled by a constant
  function automatic logic [31:0] pattern(input logic [31:0] a, input int k);
    return (a + 32'(k) * 32'd4) ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
  endtask

  // One request, the AR handshake, the R beats, the done cycle and a trailing idle cycle.
  // err_beat / rlast_beat / busy_cyc < 0 disable that disturbance (rlast_beat < 0 means last beat).
  task automatic do_burst(input string tag, input logic [31:0] addr, input int n,
                          input int ar_delay, input bit toggle, input int err_beat,
                          input int rlast_beat, input int busy_cyc,
                          input bit exp_err_req, input bit exp_err_end);
    int k;
    int dc;
    int lb;
    lb = (rlast_beat < 0) ? n - 1 : rlast_beat;
    M_RVALID     = 1'b0;
    i_data_ready = 1'b1;
    i_ctrl_read  = 1'b1;
    i_read_addr  = addr;
    i_num_trans  = 9'(n);
    @(negedge clk);
    check_eq({tag, "/idle_busy"}, 32'(o_busy), 32'd0);
    tick();
    i_ctrl_read = 1'b0;
    i_read_addr = 32'hDEAD_BEEF;
    i_num_trans = 9'd3;
    k  = 0;
    dc = 0;
    if (n == 0) begin
      @(negedge clk);
      check_eq({tag, "/zl_arvalid"}, 32'(M_ARVALID), 32'd0);
      check_eq({tag, "/zl_done"}, 32'(o_read_done), 32'd1);
      check_eq({tag, "/zl_busy"}, 32'(o_busy), 32'd1);
      check_eq({tag, "/zl_err"}, 32'(o_err), 32'(exp_err_end));
      tick();
    end else begin
      for (int d = 0; d <= ar_delay; d++) begin
        M_ARREADY = (d == ar_delay);
        @(negedge clk);
        check_eq({tag, "/arvalid"}, 32'(M_ARVALID), 32'd1);
        check_eq({tag, "/araddr"}, M_ARADDR, addr);
        check_eq({tag, "/arlen"}, 32'(M_ARLEN), 32'(n - 1));
        check_eq({tag, "/ar_rready"}, 32'(M_RREADY), 32'd0);
        if (d == 0) check_eq({tag, "/err_req"}, 32'(o_err), 32'(exp_err_req));
        tick();
      end
      M_ARREADY = 1'b0;
      while (k < n && dc < 4 * n + 8) begin
        M_RVALID     = 1'b1;
        M_RDATA      = pattern(addr, k);
        M_RRESP      = (k == err_beat) ? 2'b10 : 2'b00;
        M_RLAST      = (k == lb);
        i_data_ready = toggle ? dc[0] : 1'b1;
        i_ctrl_read  = (dc == busy_cyc);
        @(negedge clk);
        check_eq({tag, "/d_arvalid"}, 32'(M_ARVALID), 32'd0);
        check_eq({tag, "/rready"}, 32'(M_RREADY), 32'(i_data_ready));
        check_eq({tag, "/dvalid"}, 32'(o_data_valid), 32'd1);
        check_eq({tag, "/data"}, o_data, pattern(addr, k));
        check_eq({tag, "/early_done"}, 32'(o_read_done), 32'd0);
        if (i_data_ready) k++;
        dc++;
        tick();
      end
      i_ctrl_read = 1'b0;
      check_eq({tag, "/beats"}, 32'(k), 32'(n));
      check_eq({tag, "/data_cycles"}, 32'(dc), toggle ? 32'(2 * n) : 32'(n));
      // Stray beat offered in DONE must not be taken
      M_RVALID = 1'b1;
      M_RDATA  = 32'hBAD0_0000;
      M_RRESP  = 2'b00;
      M_RLAST  = 1'b0;
      i_data_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, "/done"}, 32'(o_read_done), 32'd1);
      check_eq({tag, "/done_rready"}, 32'(M_RREADY), 32'd0);
      check_eq({tag, "/done_dvalid"}, 32'(o_data_valid), 32'd0);
      check_eq({tag, "/done_busy"}, 32'(o_busy), 32'd1);
      check_eq({tag, "/err_end"}, 32'(o_err), 32'(exp_err_end));
      tick();
    end
    @(negedge clk);
    check_eq({tag, "/post_done"}, 32'(o_read_done), 32'd0);
    check_eq({tag, "/post_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "/post_rready"}, 32'(M_RREADY), 32'd0);
    check_eq({tag, "/post_arvalid"}, 32'(M_ARVALID), 32'd0);
    tick();
    M_RVALID = 1'b0;
    $display("burst %s addr=0x%08h beats=%0d data_cycles=%0d err=%0b", tag, addr, k, dc, o_err);
  endtask

  initial begin
    // Power-on reset state
    #2;
    check_eq("rst/arvalid", 32'(M_ARVALID), 32'd0);
    check_eq("rst/araddr", M_ARADDR, 32'd0);
    check_eq("rst/arlen", 32'(M_ARLEN), 32'd0);
    check_eq("rst/arsize", 32'(M_ARSIZE), 32'd2);
    check_eq("rst/arburst", 32'(M_ARBURST), 32'd1);
    check_eq("rst/arid", 32'(M_ARID), 32'd0);
    check_eq("rst/busy", 32'(o_busy), 32'd0);
    check_eq("rst/err", 32'(o_err), 32'd0);
    check_eq("rst/done", 32'(o_read_done), 32'd0);
    #10;
    rstn = 1'b1;
    tick();

    // Asynchronous reset during beat 5 of a page-crossing burst
    i_ctrl_read = 1'b1;
    i_read_addr = 32'h0000_0FF0;
    i_num_trans = 9'd16;
    tick();
    i_ctrl_read = 1'b0;
    M_ARREADY   = 1'b1;
    tick();
    M_ARREADY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      M_RVALID = 1'b1;
      M_RDATA  = pattern(32'h0000_0FF0, k);
      M_RLAST  = 1'b0;
      tick();
    end
    M_RDATA = pattern(32'h0000_0FF0, 4);
    #1;
    check_eq("mid_rst/pre_err", 32'(o_err), 32'd1);
    check_eq("mid_rst/pre_rready", 32'(M_RREADY), 32'd1);
    rstn = 1'b0;
    #0.5;
    check_eq("mid_rst/busy", 32'(o_busy), 32'd0);
    check_eq("mid_rst/err", 32'(o_err), 32'd0);
    check_eq("mid_rst/rready", 32'(M_RREADY), 32'd0);
    check_eq("mid_rst/dvalid", 32'(o_data_valid), 32'd0);
    check_eq("mid_rst/arvalid", 32'(M_ARVALID), 32'd0);
    check_eq("mid_rst/araddr", M_ARADDR, 32'd0);
    check_eq("mid_rst/arlen", 32'(M_ARLEN), 32'd0);
    check_eq("mid_rst/done", 32'(o_read_done), 32'd0);
    #0.5;
    rstn = 1'b1;
    @(negedge clk);
    check_eq("mid_rst/idle_busy", 32'(o_busy), 32'd0);
    check_eq("mid_rst/stall_rready", 32'(M_RREADY), 32'd0);
    tick();
    M_RVALID = 1'b0;
    $display("burst mid_rst addr=0x00000ff0 beats=4 reset_applied");

    do_burst("basic", 32'h1000_0040, 16, 3, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    do_burst("backpressure", 32'h1000_0100, 16, 0, 1'b1, -1, -1, -1, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++)
      do_burst($sformatf("b2b%0d", b), 32'h2000_0000 + 32'(b * 64), 16, 1, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    do_burst("page_exact", 32'h0000_0FC0, 16, 0, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    do_burst("single", 32'h0000_0FFC, 1, 0, 1'b0, -1, -1, -1, 1'b0, 1'b0);
    do_burst("zero_len", 32'h3000_0000, 0, 0, 1'b0, -1, -1, -1, 1'b0, 1'b0);

    do_burst("slverr", 32'h4000_0000, 16, 0, 1'b0, 2, -1, -1, 1'b0, 1'b1);
    apply_reset();
    do_burst("rlast_early", 32'h4000_0400, 16, 0, 1'b0, -1, 9, -1, 1'b0, 1'b1);
    apply_reset();
    do_burst("page_cross", 32'h0000_0FF0, 16, 0, 1'b0, -1, -1, -1, 1'b1, 1'b1);
    apply_reset();
    do_burst("busy_req", 32'h5000_0000, 16, 0, 1'b0, -1, -1, 5, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
